mxm_rd_streamer: RTL and testbench
==================================

// Module: mxm_rd_streamer
// PURPOSE
//  Read-side sequencer for the MXM URAM buffer (sdp_uram, P*2*8-bit words).
//  Accepts a command {base address, length} and issues one read per cycle.
//  Returns the data as a valid/ready stream with a last flag to the downstream compute stage.
//  A credit-limited output FIFO absorbs the fixed memory read latency, so backpressure never drops data.
// PARAMETERS
//  DATA_W   `P*2*8            word width, equal to the MXM memory width
//  DEPTH    `MXM_DEPTH        MXM words; AW = $clog2(DEPTH)
//  RD_LAT   `MXM_NUM_PIPE+1   cycles from mem_rd_en to a valid mem_dout
//  FIFO_D   RD_LAT+2          output FIFO entries (power of two not required)
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous reset, active-high
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       command accepted when cmd_valid&cmd_ready
//  cmd_addr     in   AW      first word address
//  cmd_len      in   AW+1    number of words; 0 is legal
//  mem_rd_en    out  1       to MXM rd_en
//  mem_rd_addr  out  AW      to MXM rd_addr
//  mem_dout     in   DATA_W  from MXM dout
//  m_valid      out  1       output word valid
//  m_ready      in   1       downstream accepts
//  m_data       out  DATA_W  output word
//  m_last       out  1       final word of the command
//  busy         out  1       command in progress (issuing, in flight or buffered)
// BEHAVIOUR
//  Reset values: cmd_ready=0 during the rst cycle and 1 afterwards in IDLE; mem_rd_en=0; mem_rd_addr=0; m_valid=0; m_last=0; busy=0.
//  FSM:
//   IDLE: cmd_ready=1. On handshake, latch addr/len.
//     len==0 -> stay IDLE, no reads, no output.
//     Otherwise go to ISSUE.
//   ISSUE: mem_rd_en=1 in a cycle iff fifo_cnt + inflight_cnt < FIFO_D.
//     Each issue increments the address and decrements the remaining count.
//     The final issue goes to DRAIN.
//   DRAIN: no issues. Go to IDLE when inflight_cnt==0 and the FIFO is empty (last word popped).
//  mem_rd_addr/mem_rd_en are registered outputs.
//   The address advances modulo DEPTH: DEPTH-1 -> 0, with no error.
//  In-flight tracking: RD_LAT-deep shift register of {vld,last}.
//   The entry is pushed at issue.
//   At the tail, vld pushes mem_dout, together with its last bit, into the FIFO.
//   inflight_cnt = popcount of vld.
//  Credit rule guarantees the FIFO never overflows. An assertion flags a push while full.
//  FIFO:
//   m_valid = !empty.
//   Pop on m_valid & m_ready.
//   Simultaneous push and pop keeps the count unchanged.
//   The output is the FIFO head: no combinational path from m_ready to m_valid.
//  m_last=1 only with the word that is the cmd_len-th of the command.
//  Throughput is 1 word/clk when m_ready is held high.
//   First m_valid comes RD_LAT+2 cycles after the cmd handshake: 1 cycle issue register, RD_LAT memory, 1 cycle FIFO write.
//  m_valid/m_data/m_last stay stable while m_valid & !m_ready.
//  busy = state!=IDLE.
//   The next command is accepted only in IDLE, so commands never overlap.
//  Reset mid-operation:
//   Clears FSM, counters, vld pipe and FIFO pointers.
//   Memory data arriving after reset is ignored, because its vld bit has been cleared.
// STRUCTURE
//  Package/include (incl.vh): `P, `MXM_DEPTH, `MXM_NUM_PIPE.
//   The MXM_RD_LAT define (=`MXM_NUM_PIPE+1) is shared with the MXM writer.
//  One sub-module: mxm_rd_fifo.
//   Synchronous FIFO: FIFO_D x (DATA_W+1), registered-output, count port.
//  FSM, issue logic and vld/last shift register live in the top module.
// TESTING (memory model = sdp_uram with RD_LAT latency, preloaded mem[i]=i)
//  1. cmd addr=5 len=4, m_ready=1.
//     -> words 5,6,7,8 on 4 consecutive cycles; m_last on 8.
//     -> first m_valid exactly RD_LAT+2 cycles after handshake.
//  2. cmd addr=DEPTH-2 len=4.
//     -> words DEPTH-2, DEPTH-1, 0, 1; last on 1.
//  3. len=64, m_ready random 30% duty.
//     -> all 64 words in order, none lost or duplicated.
//     -> mem_rd_en stalls once fifo_cnt+inflight reaches FIFO_D; FIFO-full assertion never fires.
//  4. cmd len=0.
//     -> no mem_rd_en, no m_valid; cmd_ready stays 1; next cmd addr=0 len=1 returns word 0 with last.
//  5. Assert rst for 1 cycle mid-command, with 3 reads in flight.
//     -> next cycle: m_valid=0, busy=0, mem_rd_en=0.
//     -> no stale word appears later; a new cmd then streams correctly.
//  6. Back-to-back cmds (len=3 then len=2).
//     -> second cmd_ready only after first last pop; 5 words total, 2 last flags.

Source files
------------

// File: rtl/mxm_rd_streamer_pkg.sv
// rtl/mxm_rd_streamer_pkg.sv - shared MXM geometry, read latency and streamer FSM encoding
package mxm_rd_streamer_pkg;

    localparam int MXM_P        = 4;
    localparam int MXM_DATA_W   = MXM_P * 2 * 8;
    localparam int MXM_DEPTH    = 64;
    localparam int MXM_NUM_PIPE = 2;
    // Also consumed by the MXM writer, keep the two in lockstep.
    localparam int MXM_RD_LAT   = MXM_NUM_PIPE + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    function automatic int popcount(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/mxm_rd_fifo.sv
// rtl/mxm_rd_fifo.sv - synchronous output FIFO with count, head read straight from storage
module mxm_rd_fifo #(
    parameter int  W  = 65,
    parameter int  D  = 5,
    localparam int PW = (D > 1) ? $clog2(D) : 1,
    localparam int CW = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head_data,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_q [D];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          full;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage write; contents need no reset because the count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together leaves the count alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CW'(D));
    assign count     = cnt_q;

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/mxm_rd_streamer.sv
// rtl/mxm_rd_streamer.sv - command-driven MXM read sequencer with credit-limited output stream
module mxm_rd_streamer
    import mxm_rd_streamer_pkg::*;
#(
    parameter int  DATA_W = MXM_DATA_W,
    parameter int  DEPTH  = MXM_DEPTH,
    parameter int  RD_LAT = MXM_RD_LAT,
    parameter int  FIFO_D = RD_LAT + 2,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [AW:0]       cmd_len,
    output logic              mem_rd_en,
    output logic [AW-1:0]     mem_rd_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy
);

    localparam int CW = $clog2(FIFO_D + 1);

    rd_state_e         state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [AW:0]       rem_q, rem_d;
    logic              rd_en_q;
    logic              rd_last_q;
    logic [AW-1:0]     rd_addr_q;
    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] lst_q;

    logic [CW-1:0]     fifo_cnt;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_head;
    logic              cmd_fire;
    logic              issue;
    logic              pop;
    logic              inflight_none;
    logic              final_issue;
    int                outstanding;

    // Credit check: everything issued but not yet popped, less a word leaving this cycle.
    always_comb begin
        outstanding   = int'(fifo_cnt) + int'(rd_en_q) + popcount(32'(vld_q)) - int'(pop);
        issue         = (state_q == ST_ISSUE) && (outstanding < FIFO_D);
        final_issue   = issue && (rem_q == (AW + 1)'(1));
        cmd_fire      = cmd_valid && cmd_ready;
        inflight_none = !rd_en_q && (vld_q == '0);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state: zero-length commands never leave IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cmd_fire && (cmd_len != '0)) state_d = ST_ISSUE;
            ST_ISSUE: if (final_issue) state_d = ST_DRAIN;
            ST_DRAIN: if (inflight_none && fifo_empty) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; a command is refused while reset is asserted.
    always_comb begin
        cmd_ready = (state_q == ST_IDLE) && !rst;
        busy      = (state_q != ST_IDLE);
    end

    // Address/remaining-count next values; address wraps modulo DEPTH.
    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (cmd_fire) begin
            addr_d = cmd_addr;
            rem_d  = cmd_len;
        end else if (issue) begin
            addr_d = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
            rem_d  = rem_q - (AW + 1)'(1);
        end
    end

    // Issue registers and the vld/last tracker that tags memory data arriving RD_LAT later.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            rem_q     <= '0;
            rd_en_q   <= 1'b0;
            rd_last_q <= 1'b0;
            rd_addr_q <= '0;
            vld_q     <= '0;
            lst_q     <= '0;
        end else begin
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            rd_en_q   <= issue;
            rd_last_q <= final_issue;
            if (issue) rd_addr_q <= addr_q;
            vld_q[0]  <= rd_en_q;
            lst_q[0]  <= rd_last_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                lst_q[i] <= lst_q[i-1];
            end
        end
    end

    assign mem_rd_en   = rd_en_q;
    assign mem_rd_addr = rd_addr_q;
    assign pop         = m_valid && m_ready;

    mxm_rd_fifo #(
        .W (DATA_W + 1),
        .D (FIFO_D)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vld_q[RD_LAT-1]),
        .push_data ({lst_q[RD_LAT-1], mem_dout}),
        .pop       (pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = fifo_head[DATA_W-1:0];
    assign m_last  = m_valid && fifo_head[DATA_W];

endmodule

// File: tb/tb_mxm_rd_streamer.sv
// tb/tb_mxm_rd_streamer.sv - self-checking bench for mxm_rd_streamer
module tb_mxm_rd_streamer;
    import mxm_rd_streamer_pkg::*;

    localparam int DATA_W = MXM_DATA_W;
    localparam int DEPTH  = MXM_DEPTH;
    localparam int RD_LAT = MXM_RD_LAT;
    localparam int FIFO_D = RD_LAT + 2;
    localparam int AW     = $clog2(DEPTH);

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [AW-1:0]     cmd_addr;
    logic [AW:0]       cmd_len;
    logic              mem_rd_en;
    logic [AW-1:0]     mem_rd_addr;
    logic [DATA_W-1:0] mem_dout;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              busy;

    mxm_rd_streamer dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_dout    (mem_dout),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: mem[i] = i, data valid RD_LAT cycles after the rd_en cycle.
    logic [DATA_W-1:0] dpipe [RD_LAT];
    always @(posedge clk) begin
        dpipe[0] <= mem_rd_en ? DATA_W'(mem_rd_addr) : {DATA_W{1'b1}};
        for (int i = 1; i < RD_LAT; i++) dpipe[i] <= dpipe[i-1];
    end
    assign mem_dout = dpipe[RD_LAT-1];

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    typedef struct {
        int addr;
        int len;
        int pct;
        bit chk_lat;
        bit chk_full;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];

    int errors = 0, checks = 0;
    int cyc = 0, ready_pct = 100;
    int issued, pops, lasts, outst, max_outst, first_pop_cyc, last_pop_cyc;
    bit prev_stall = 0;
    logic [DATA_W-1:0] prev_data;
    logic prev_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_counters();
        issued = 0; pops = 0; lasts = 0; outst = 0; max_outst = 0;
        first_pop_cyc = 0; last_pop_cyc = 0;
    endtask

    // Drives m_ready, then scores the handshake the next posedge will take.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 0;
        end else begin
            m_ready = (int'($urandom_range(99)) < ready_pct);
            if (mem_rd_en) issued++;
            outst = issued - pops;
            if (outst > max_outst) max_outst = outst;
            if (prev_stall) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, prev_data);
                check("hold_last", m_last, prev_last);
            end
            if (m_valid && m_ready) begin
                pops++;
                if (m_last) lasts++;
                if (pops == 1) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none", m_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("m_data", m_data, e.data);
                    check("m_last", m_last, e.last);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic send_cmd(input int a, input int l);
        int g;
        g = 0;
        @(negedge clk);
        for (int i = 0; i < l; i++) exp_q.push_back('{DATA_W'((a + i) % DEPTH), (i == l - 1)});
        cmd_addr  = AW'(a);
        cmd_len   = (AW + 1)'(l);
        cmd_valid = 1'b1;
        while (!cmd_ready && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 5000) check("cmd_accept_timeout", g, 0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 5000) check("idle_timeout", g, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        bit saw_rd, saw_v, saw_nrdy;
        @(posedge clk);
        reset_counters();
        ready_pct = v.pct;
        send_cmd(v.addr, v.len);
        if (v.len == 0) begin
            saw_rd = 0; saw_v = 0; saw_nrdy = 0;
            repeat (8) begin
                @(negedge clk);
                saw_rd   |= mem_rd_en;
                saw_v    |= m_valid;
                saw_nrdy |= !cmd_ready;
            end
            check("len0_no_read", saw_rd, 0);
            check("len0_no_valid", saw_v, 0);
            check("len0_cmd_ready", saw_nrdy, 0);
        end else if (v.chk_lat) begin
            lat = 0;
            while (!m_valid && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            check("first_latency", lat, RD_LAT + 2);
        end
        wait_idle();
        check("issue_count", issued, v.len);
        check("word_count", pops, v.len);
        check("last_count", lasts, (v.len != 0) ? 1 : 0);
        if (v.pct == 100 && v.len > 0) check("stream_span", last_pop_cyc - first_pop_cyc, v.len - 1);
        check("credit_bound", max_outst <= FIFO_D, 1);
        if (v.chk_full) check("credit_reached", max_outst, FIFO_D);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit saw_v;
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_ready = 1'b0;
        reset_counters();

        vecs.push_back('{5, 4, 100, 1, 0});
        vecs.push_back('{DEPTH - 2, 4, 100, 1, 0});
        vecs.push_back('{0, 64, 30, 0, 1});
        vecs.push_back('{0, 0, 100, 0, 0});
        vecs.push_back('{0, 1, 100, 1, 0});
        for (int i = 0; i < 6; i++)
            vecs.push_back('{int'($urandom_range(DEPTH - 1)), int'($urandom_range(20)),
                             int'($urandom_range(20, 100)), 0, 0});

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_mem_rd_en", mem_rd_en, 0);
        check("rst_mem_rd_addr", mem_rd_addr, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Reset with three reads in flight
        @(posedge clk);
        reset_counters();
        ready_pct = 100;
        send_cmd(10, 20);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check("midrst_m_valid", m_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_mem_rd_en", mem_rd_en, 0);
        saw_v = 0;
        repeat (12) begin
            @(negedge clk);
            saw_v |= m_valid;
        end
        check("midrst_no_stale", saw_v, 0);
        run_vec('{7, 5, 100, 1, 0});

        // Back-to-back commands: second waits for the first last pop
        @(posedge clk);
        reset_counters();
        ready_pct = 100;
        send_cmd(20, 3);
        send_cmd(40, 2);
        check("b2b_last_before_accept", lasts, 1);
        check("b2b_words_before_accept", pops, 3);
        wait_idle();
        check("b2b_words", pops, 5);
        check("b2b_lasts", lasts, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
